// File: rtl/dw_mult_seq.sv
// Sequential radix-2 shift-add multiplier with a signed/unsigned mode, flush and output backpressure.
// Define DW_MULT_SEQ_EARLY_TERM_EN to end CALC as soon as the remaining multiplier bits are zero.
module dw_mult_seq #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       tc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       busy
);

  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(B_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [P-1:0]       mcand;
  logic [P-1:0]       acc;
  logic [P-1:0]       acc_step;
  logic [P-1:0]       product_q;
  logic [B_WIDTH-1:0] mult;
  logic [CW-1:0]      cnt;
  logic               sign;
  logic               last_step;
  logic               accept;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;

  // Magnitudes are held unsigned, so the most negative operand maps to 2^(W-1) without overflow.
  assign a_mag    = (tc && a[A_WIDTH-1]) ? -a : a;
  assign b_mag    = (tc && b[B_WIDTH-1]) ? -b : b;
  assign accept   = (state == IDLE) && in_valid && !flush;
  assign acc_step = mult[0] ? (acc + mcand) : acc;

`ifdef DW_MULT_SEQ_EARLY_TERM_EN
  assign last_step = (mult[B_WIDTH-1:1] == '0) || (cnt == CW'(B_WIDTH - 1));
`else
  assign last_step = (cnt == CW'(B_WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // flush outranks out_ready and in_valid in every state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    if (flush || out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      acc       <= '0;
      mult      <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      product_q <= '0;
    end else if (accept) begin
      mcand <= P'(a_mag);
      mult  <= b_mag;
      acc   <= '0;
      cnt   <= '0;
      sign  <= tc & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
    end else if (state == CALC && !flush) begin
      acc   <= acc_step;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      cnt   <= cnt + CW'(1);
      // product is loaded only on the edge entering DONE and retained afterwards.
      if (last_step) product_q <= sign ? -acc_step : acc_step;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = product_q;

endmodule

// File: tb/tb_dw_mult_seq.sv
// Directed bench for dw_mult_seq at 8x8: products, latency, backpressure, flush and reset abort.
// Latency expectations follow DW_MULT_SEQ_EARLY_TERM_EN when the bench is built with it.
module tb_dw_mult_seq;

`ifdef DW_MULT_SEQ_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        tc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int checks;
  int failures;

  // a, b, tc, product, early-termination latency
  localparam logic [7:0]  VA [12] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00, 8'hFD,
                                      8'hFD, 8'h7F, 8'hFF, 8'h12, 8'hC4, 8'h80};
  localparam logic [7:0]  VB [12] = '{8'h02, 8'h02, 8'h80, 8'h7F, 8'h85, 8'h05,
                                      8'h05, 8'h81, 8'hFF, 8'h01, 8'h00, 8'h80};
  localparam logic        VT [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] VP [12] = '{16'hFFFE, 16'h01FE, 16'h4000, 16'hC080, 16'h0000, 16'hFFF1,
                                      16'h04F1, 16'hC0FF, 16'hFE01, 16'h0012, 16'h0000, 16'h4000};
  localparam int          VL [12] = '{2, 2, 8, 7, 7, 3, 3, 7, 8, 1, 1, 8};

  dw_mult_seq #(.A_WIDTH(8), .B_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tc        (tc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input int et);
    return ET ? et : 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called just after a negedge; accepts on the next edge, scrambles operands, waits for out_valid.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic tcv,
                        output logic [15:0] prod, output int lat);
    in_valid = 1'b1;
    a = av;
    b = bv;
    tc = tcv;
    tick();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    tc = ~tcv;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    prod = product;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs got in_ready=%b out_valid=%b busy=%b product=%h exp 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_products();
    logic [15:0] prod;
    int lat;
    for (int i = 0; i < 12; i++) begin
      run_op(VA[i], VB[i], VT[i], prod, lat);
      checks++;
      if (prod !== VP[i]) begin
        failures++;
        $display("FAIL product[%0d] got=%h exp=%h", i, prod, VP[i]);
      end
      checks++;
      if (lat != exp_lat(VL[i])) begin
        failures++;
        $display("FAIL latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(VL[i]));
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL done_flags[%0d] got in_ready=%b busy=%b exp 0 1", i, in_ready, busy);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL release[%0d] got in_ready=%b out_valid=%b exp 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] prod;
    int lat;
    int bad;
    run_op(8'h0B, 8'h0D, 1'b0, prod, lat);
    checks++;
    if (prod !== 16'h008F || lat != exp_lat(4)) begin
      failures++;
      $display("FAIL bp_result got=%h lat=%0d exp=008f lat=%0d", prod, lat, exp_lat(4));
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'h008F) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_overlap got in_ready=%b exp 0", in_ready);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h008F) begin
      failures++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b product=%h exp 1 0 008f",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_flush();
    logic [15:0] prod;
    int lat;
    int seen;
    in_valid = 1'b1;
    a = 8'h03;
    b = 8'h05;
    tc = 1'b0;
    flush = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_blocks_accept got in_ready=%b busy=%b exp 1 0", in_ready, busy);
    end
    flush = 1'b0;
    a = 8'h07;
    b = 8'hC0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_no_valid got %0d valid cycles exp 0", seen);
    end
    run_op(8'h03, 8'h05, 1'b0, prod, lat);
    checks++;
    if (prod !== 16'h000F || lat != exp_lat(3)) begin
      failures++;
      $display("FAIL after_flush got=%h lat=%0d exp=000f lat=%0d", prod, lat, exp_lat(3));
    end
    release_out();
    run_op(8'h10, 8'h10, 1'b0, prod, lat);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0100) begin
      failures++;
      $display("FAIL flush_done got in_ready=%b out_valid=%b product=%h exp 1 0 0100",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] prod;
    int lat;
    int seen;
    in_valid = 1'b1;
    a = 8'h21;
    b = 8'hC3;
    tc = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid got in_ready=%b out_valid=%b busy=%b product=%h exp 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_valid got %0d valid cycles exp 0", seen);
    end
    // Accept on the first edge after release.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h06, 8'h07, 1'b0, prod, lat);
    checks++;
    if (prod !== 16'h002A || lat != exp_lat(3)) begin
      failures++;
      $display("FAIL first_accept got=%h lat=%0d exp=002a lat=%0d", prod, lat, exp_lat(3));
    end
    release_out();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    tc = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_products();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
